pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 3: number of pipeline-flush cycles after reset release.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports d_icode, e_icode, m_icode  input  4 each  icodes held in the D, E and M pipeline registers.
REQ-005 SHALL have ports d_srcA, d_srcB  input  4 each  decode-stage source register IDs.
REQ-006 SHALL have port e_dstM  input  4  E-register memory destination register ID.
REQ-007 SHALL have port e_Cnd  input  1  execute-stage branch condition.
REQ-008 SHALL have ports m_stat, w_stat  input  3 each  memory-stage status and W-register status.
REQ-009 SHALL have outputs f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc  output  1 each  pipeline-register controls and CC write enable.
REQ-010 SHALL have port cpu_stat  output  3  latched processor status.
REQ-011 SHALL have port halted  output  1  high in STOP state.
REQ-012 SHALL have ports cycle_cnt, lu_cnt, mp_cnt  output  32 each  run-cycle, load-use-stall and mispredict counters.

Function
REQ-013 SHALL implement three states: FLUSH, RUN, STOP.
REQ-014 SHALL, in FLUSH, drive d_bubble=e_bubble=m_bubble=1, all stalls 0, set_cc=0; flush counter decrements each cycle; FLUSH->RUN when it reaches 0, giving exactly FLUSH_CYCLES flush cycles.
REQ-015 SHALL define load_use = (e_icode in {MRMOVQ=5, POPQ=0xB}) AND e_dstM != RNONE(0xF) AND (e_dstM == d_srcA OR e_dstM == d_srcB).
REQ-016 SHALL define ret_hz = RET(9) in {d_icode, e_icode, m_icode}; mispred = e_icode==JXX(7) AND e_Cnd==0.
REQ-017 SHALL define exc(s) = s in {HLT=2, ADR=3, INS=4}; AOK=1.
REQ-018 SHALL, in RUN: f_stall = load_use OR ret_hz; d_stall = load_use; d_bubble = mispred OR (ret_hz AND NOT load_use); e_bubble = mispred OR load_use; m_bubble = exc(m_stat) OR exc(w_stat); w_stall = exc(w_stat).
REQ-019 SHALL, in RUN, drive set_cc = (e_icode==OPQ(6)) AND NOT exc(m_stat) AND NOT exc(w_stat).
REQ-020 SHALL, all outputs being combinational from state and inputs, transition RUN->STOP on the cycle w_stat is exc, latching w_stat into cpu_stat on that edge.
REQ-021 SHALL hold STOP until reset; in STOP f_stall=d_stall=w_stall=1, all bubbles 0, set_cc 0, halted 1.
REQ-022 SHALL, in FLUSH and RUN, present cpu_stat = AOK.
REQ-023 SHALL increment cycle_cnt every RUN cycle, lu_cnt each RUN cycle with load_use, mp_cnt each RUN cycle with mispred; counters wrap modulo 2^32 and freeze in FLUSH and STOP.
REQ-024 SHALL give load_use priority over ret_hz when both hold (D stalls, not bubbles).
REQ-025 SHALL, when mispred and load_use coincide, assert e_bubble once and count both lu_cnt and mp_cnt.

Reset
REQ-026 SHALL, when rst_n=0 at posedge clk, enter FLUSH with flush counter = FLUSH_CYCLES-1, clear all counters, set cpu_stat=AOK, halted=0; outputs during reset follow FLUSH values.
REQ-027 SHALL give reset priority over every transition, including reset asserted in STOP or mid-FLUSH.

Structure
REQ-028 SHALL take icode constants (HALT..POPQ), RNONE and status codes (AOK, HLT, ADR, INS) from a shared y86 package also used by the stage modules.
REQ-029 SHALL place hazard detection (REQ-015..019) in one combinational sub-module hazard_unit; state machine and counters remain in pipe_ctrl.

Verification
REQ-030 SHALL cover reset release: rst_n 0->1 -> d/e/m_bubble high for exactly 3 cycles, then RUN, cycle_cnt starts at 1.
REQ-031 SHALL cover load-use: e_icode=5, e_dstM=3, d_srcB=3 -> f_stall=d_stall=e_bubble=1, d_bubble=0, lu_cnt +1; with e_dstM=0xF, d_srcA=0xF -> no stall.
REQ-032 SHALL cover mispredict: e_icode=7, e_Cnd=0 -> d_bubble=e_bubble=1, mp_cnt +1; e_Cnd=1 -> none.
REQ-033 SHALL cover ret: d_icode=9 -> f_stall=1, d_bubble=1; with load_use also true -> d_stall=1, d_bubble=0.
REQ-034 SHALL cover halt: m_stat=2 -> m_bubble=1, set_cc=0 with e_icode=6; next w_stat=2 -> STOP, cpu_stat=2, halted=1, counters frozen; rst_n=0 -> FLUSH.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs, status codes and the
// pipeline controller state type.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IcHalt   = 4'h0;
    localparam logic [3:0] IcNop    = 4'h1;
    localparam logic [3:0] IcRrmovq = 4'h2;
    localparam logic [3:0] IcIrmovq = 4'h3;
    localparam logic [3:0] IcRmmovq = 4'h4;
    localparam logic [3:0] IcMrmovq = 4'h5;
    localparam logic [3:0] IcOpq    = 4'h6;
    localparam logic [3:0] IcJxx    = 4'h7;
    localparam logic [3:0] IcCall   = 4'h8;
    localparam logic [3:0] IcRet    = 4'h9;
    localparam logic [3:0] IcPushq  = 4'hA;
    localparam logic [3:0] IcPopq   = 4'hB;

    // "No register" ID
    localparam logic [3:0] RNone = 4'hF;

    // Status codes
    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef enum logic [1:0] {
        StFlush = 2'd0,
        StRun   = 2'd1,
        StStop  = 2'd2
    } ctrl_state_e;

    // True for statuses that must stop the processor.
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == StatHlt) || (stat == StatAdr) || (stat == StatIns);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: computes the pipeline-register controls that
// apply while the processor is running, plus the raw hazard flags for counting.
module hazard_unit
    import y86_pkg::*;
(
    input  logic [3:0] d_icode_i,
    input  logic [3:0] e_icode_i,
    input  logic [3:0] m_icode_i,
    input  logic [3:0] d_src_a_i,
    input  logic [3:0] d_src_b_i,
    input  logic [3:0] e_dst_m_i,
    input  logic       e_cnd_i,
    input  logic [2:0] m_stat_i,
    input  logic [2:0] w_stat_i,
    output logic       load_use_o,
    output logic       mispred_o,
    output logic       w_exc_o,
    output logic       f_stall_o,
    output logic       d_stall_o,
    output logic       d_bubble_o,
    output logic       e_bubble_o,
    output logic       m_bubble_o,
    output logic       w_stall_o,
    output logic       set_cc_o
);

    logic e_is_load;
    logic ret_hz;
    logic m_exc;

    // Hazard classification and run-mode control derivation
    always_comb begin
        e_is_load  = (e_icode_i == IcMrmovq) || (e_icode_i == IcPopq);
        load_use_o = e_is_load && (e_dst_m_i != RNone) &&
                     ((e_dst_m_i == d_src_a_i) || (e_dst_m_i == d_src_b_i));
        ret_hz     = (d_icode_i == IcRet) || (e_icode_i == IcRet) || (m_icode_i == IcRet);
        mispred_o  = (e_icode_i == IcJxx) && !e_cnd_i;
        m_exc      = is_exc(m_stat_i);
        w_exc_o    = is_exc(w_stat_i);

        f_stall_o  = load_use_o || ret_hz;
        d_stall_o  = load_use_o;
        // A load-use stall holds D, so a pending ret must not also bubble it.
        d_bubble_o = mispred_o || (ret_hz && !load_use_o);
        e_bubble_o = mispred_o || load_use_o;
        m_bubble_o = m_exc || w_exc_o;
        w_stall_o  = w_exc_o;
        // Freeze condition codes once an exception is in flight downstream.
        set_cc_o   = (e_icode_i == IcOpq) && !m_exc && !w_exc_o;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline controller: post-reset flush sequencing, run-mode hazard
// control, halt on writeback exception, and performance counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  d_icode,
    input  logic [3:0]  e_icode,
    input  logic [3:0]  m_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  e_dstM,
    input  logic        e_Cnd,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  w_stat,
    output logic        f_stall,
    output logic        d_stall,
    output logic        d_bubble,
    output logic        e_bubble,
    output logic        m_bubble,
    output logic        w_stall,
    output logic        set_cc,
    output logic [2:0]  cpu_stat,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] lu_cnt,
    output logic [31:0] mp_cnt
);

    // Flush counter holds "remaining flush cycles minus one"; FLUSH_CYCLES must be >= 1.
    localparam int unsigned FcW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FcW-1:0] FlushInit = FcW'(FLUSH_CYCLES - 1);

    ctrl_state_e    state_q, state_d;
    logic [FcW-1:0] flush_cnt_q, flush_cnt_d;
    logic [2:0]     cpu_stat_q, cpu_stat_d;
    logic [31:0]    cycle_cnt_q, cycle_cnt_d;
    logic [31:0]    lu_cnt_q, lu_cnt_d;
    logic [31:0]    mp_cnt_q, mp_cnt_d;

    logic hz_load_use, hz_mispred, hz_w_exc;
    logic hz_f_stall, hz_d_stall, hz_d_bubble, hz_e_bubble;
    logic hz_m_bubble, hz_w_stall, hz_set_cc;

    hazard_unit u_hazard_unit (
        .d_icode_i  (d_icode),
        .e_icode_i  (e_icode),
        .m_icode_i  (m_icode),
        .d_src_a_i  (d_srcA),
        .d_src_b_i  (d_srcB),
        .e_dst_m_i  (e_dstM),
        .e_cnd_i    (e_Cnd),
        .m_stat_i   (m_stat),
        .w_stat_i   (w_stat),
        .load_use_o (hz_load_use),
        .mispred_o  (hz_mispred),
        .w_exc_o    (hz_w_exc),
        .f_stall_o  (hz_f_stall),
        .d_stall_o  (hz_d_stall),
        .d_bubble_o (hz_d_bubble),
        .e_bubble_o (hz_e_bubble),
        .m_bubble_o (hz_m_bubble),
        .w_stall_o  (hz_w_stall),
        .set_cc_o   (hz_set_cc)
    );

    // State, flush counter, status latch and counters; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFlush;
            flush_cnt_q <= FlushInit;
            cpu_stat_q  <= StatAok;
            cycle_cnt_q <= 32'd0;
            lu_cnt_q    <= 32'd0;
            mp_cnt_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            cpu_stat_q  <= cpu_stat_d;
            cycle_cnt_q <= cycle_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
            mp_cnt_q    <= mp_cnt_d;
        end
    end

    // Next-state logic: flush countdown, run-mode counting, halt detection
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        cpu_stat_d  = cpu_stat_q;
        cycle_cnt_d = cycle_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        mp_cnt_d    = mp_cnt_q;
        unique case (state_q)
            StFlush: begin
                if (flush_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - FcW'(1);
                end
            end
            StRun: begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
                if (hz_load_use) lu_cnt_d = lu_cnt_q + 32'd1;
                if (hz_mispred)  mp_cnt_d = mp_cnt_q + 32'd1;
                if (hz_w_exc) begin
                    state_d    = StStop;
                    cpu_stat_d = w_stat;
                end
            end
            StStop: begin
                state_d = StStop;
            end
            default: begin
                state_d     = StFlush;
                flush_cnt_d = FlushInit;
            end
        endcase
    end

    // Output decode; reset cycles present the flush controls
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_stall  = 1'b0;
        set_cc   = 1'b0;
        cpu_stat = StatAok;
        halted   = 1'b0;
        if (!rst_n) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    f_stall  = hz_f_stall;
                    d_stall  = hz_d_stall;
                    d_bubble = hz_d_bubble;
                    e_bubble = hz_e_bubble;
                    m_bubble = hz_m_bubble;
                    w_stall  = hz_w_stall;
                    set_cc   = hz_set_cc;
                end
                StStop: begin
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    w_stall  = 1'b1;
                    cpu_stat = cpu_stat_q;
                    halted   = 1'b1;
                end
                default: begin
                    d_bubble = 1'b1;
                    e_bubble = 1'b1;
                    m_bubble = 1'b1;
                end
            endcase
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign lu_cnt    = lu_cnt_q;
    assign mp_cnt    = mp_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned FLUSH = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  d_icode, e_icode, m_icode, d_srcA, d_srcB, e_dstM;
    logic        e_Cnd;
    logic [2:0]  m_stat, w_stat;
    logic        f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;
    logic [2:0]  cpu_stat;
    logic        halted;
    logic [31:0] cycle_cnt, lu_cnt, mp_cnt;

    int nchecks = 0;
    int nfail   = 0;

    // Behavioural model: mode 0=flush, 1=run, 2=stop
    bit          m_valid = 1'b0;
    int          m_mode  = 0;
    int          m_left  = 0;
    int unsigned m_cyc = 0, m_lu = 0, m_mp = 0;
    logic [2:0]  m_latched = 3'd1;

    pipe_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_icode   (d_icode),
        .e_icode   (e_icode),
        .m_icode   (m_icode),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .e_dstM    (e_dstM),
        .e_Cnd     (e_Cnd),
        .m_stat    (m_stat),
        .w_stat    (w_stat),
        .f_stall   (f_stall),
        .d_stall   (d_stall),
        .d_bubble  (d_bubble),
        .e_bubble  (e_bubble),
        .m_bubble  (m_bubble),
        .w_stall   (w_stall),
        .set_cc    (set_cc),
        .cpu_stat  (cpu_stat),
        .halted    (halted),
        .cycle_cnt (cycle_cnt),
        .lu_cnt    (lu_cnt),
        .mp_cnt    (mp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctl_vec();
        return {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc};
    endfunction

    function automatic bit exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    // One clock: compare at negedge against the model, advance the model, return at posedge+1
    task automatic cycle();
        bit lu, rh, mp, me, we;
        logic [6:0] exp_ctl;
        logic [2:0] exp_stat;
        bit exp_halt;
        @(negedge clk);
        lu = ((e_icode == 4'h5) || (e_icode == 4'hB)) && (e_dstM != 4'hF) &&
             ((e_dstM == d_srcA) || (e_dstM == d_srcB));
        rh = (d_icode == 4'h9) || (e_icode == 4'h9) || (m_icode == 4'h9);
        mp = (e_icode == 4'h7) && !e_Cnd;
        me = exc(m_stat);
        we = exc(w_stat);
        if (m_valid) begin
            if (!rst_n || m_mode == 0) begin
                exp_ctl = 7'b0011100; exp_stat = 3'd1; exp_halt = 1'b0;
            end else if (m_mode == 1) begin
                exp_ctl = {lu | rh, lu, mp | (rh & !lu), mp | lu, me | we, we,
                           (e_icode == 4'h6) & !me & !we};
                exp_stat = 3'd1; exp_halt = 1'b0;
            end else begin
                exp_ctl = 7'b1100010; exp_stat = m_latched; exp_halt = 1'b1;
            end
            check("controls", 32'(ctl_vec()), 32'(exp_ctl));
            check("cpu_stat", 32'(cpu_stat), 32'(exp_stat));
            check("halted", 32'(halted), 32'(exp_halt));
            check("cycle_cnt", cycle_cnt, m_cyc);
            check("lu_cnt", lu_cnt, m_lu);
            check("mp_cnt", mp_cnt, m_mp);
        end
        if (!rst_n) begin
            m_valid = 1'b1; m_mode = 0; m_left = FLUSH;
            m_cyc = 0; m_lu = 0; m_mp = 0; m_latched = 3'd1;
        end else if (m_valid) begin
            if (m_mode == 0) begin
                m_left--;
                if (m_left == 0) m_mode = 1;
            end else if (m_mode == 1) begin
                m_cyc++;
                if (lu) m_lu++;
                if (mp) m_mp++;
                if (we) begin
                    m_mode = 2;
                    m_latched = w_stat;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic neutral();
        d_icode = 4'h1; e_icode = 4'h1; m_icode = 4'h1;
        d_srcA = 4'h0; d_srcB = 4'h0; e_dstM = 4'hF;
        e_Cnd = 1'b1; m_stat = 3'd1; w_stat = 3'd1;
    endtask

    function automatic logic [3:0] pick_reg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    initial begin
        int nflush;
        rst_n = 1'b0;
        neutral();
        cycle();
        cycle();

        // Reset release: exactly FLUSH bubble cycles, then RUN
        rst_n = 1'b1;
        nflush = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (d_bubble && e_bubble && m_bubble) nflush++;
            if (i == 4) check("cycle_cnt_first", cycle_cnt, 32'd1);
            cycle();
        end
        check("flush_len", 32'(nflush), 32'd3);

        // Load-use
        e_icode = 4'h5; e_dstM = 4'h3; d_srcB = 4'h3; #1;
        check("lu_ctl", 32'(ctl_vec()), 32'b1101000);
        cycle();
        check("lu_cnt_inc", lu_cnt, 32'd1);
        e_dstM = 4'hF; d_srcA = 4'hF; #1;
        check("lu_rnone", 32'(ctl_vec()), 32'b0000000);
        cycle();

        // Mispredict
        neutral(); e_icode = 4'h7; e_Cnd = 1'b0; #1;
        check("mp_ctl", 32'(ctl_vec()), 32'b0011000);
        cycle();
        check("mp_cnt_inc", mp_cnt, 32'd1);
        e_Cnd = 1'b1; #1;
        check("mp_taken", 32'(ctl_vec()), 32'b0000000);
        cycle();

        // Ret, alone and with a load-use
        neutral(); d_icode = 4'h9; #1;
        check("ret_ctl", 32'(ctl_vec()), 32'b1010000);
        cycle();
        e_icode = 4'h5; e_dstM = 4'h3; d_srcB = 4'h3; #1;
        check("ret_lu_ctl", 32'(ctl_vec()), 32'b1101000);
        cycle();

        // Halt
        neutral(); e_icode = 4'h6; m_stat = 3'd2; #1;
        check("halt_m_ctl", 32'(ctl_vec()), 32'b0000100);
        cycle();
        e_icode = 4'h1; m_stat = 3'd1; w_stat = 3'd2; #1;
        check("halt_w_ctl", 32'(ctl_vec()), 32'b0000110);
        check("halt_w_running", 32'(halted), 32'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            neutral(); e_icode = 4'h5; e_dstM = 4'h3; d_srcA = 4'h3; #1;
            check("stop_ctl", 32'(ctl_vec()), 32'b1100010);
            check("stop_stat", 32'(cpu_stat), 32'd2);
            check("stop_halted", 32'(halted), 32'd1);
            check("stop_cyc", cycle_cnt, 32'd10);
            check("stop_lu", lu_cnt, 32'd2);
            check("stop_mp", mp_cnt, 32'd1);
            cycle();
        end

        // Reset from STOP
        rst_n = 1'b0; neutral(); #1;
        check("rst_ctl", 32'(ctl_vec()), 32'b0011100);
        check("rst_stat", 32'(cpu_stat), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        cycle();
        check("rst_cyc_clr", cycle_cnt, 32'd0);
        check("rst_lu_clr", lu_cnt, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            if (m_mode == 2 && $urandom_range(0, 9) == 0) rst_n = 1'b0;
            d_icode = 4'($urandom_range(0, 11));
            e_icode = 4'($urandom_range(0, 11));
            m_icode = 4'($urandom_range(0, 11));
            d_srcA  = pick_reg();
            d_srcB  = pick_reg();
            e_dstM  = pick_reg();
            e_Cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            w_stat  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
